edge_detector_mc: RTL and testbench
===================================

// Module: edge_detector_mc
// PURPOSE
//   Multi-channel successor to the single-bit edge detector. Per channel: synchronise an async
//   input, debounce it, emit one-cycle pos/neg edge pulses. Edges are qualified by a
//   per-channel mode into sticky pending flags and saturating event counters.
//   Sits between raw external strobes and control logic / status registers.
// PARAMETERS
//   N_CH         4   number of independent channels (>=1)
//   SYNC_STAGES  2   synchroniser flops per channel (>=2)
//   DEBOUNCE     4   consecutive stable synced cycles before the filtered level flips (>=1; 1 = no filter)
//   CNT_W        8   width of each per-channel event counter (>=1)
// PORTS
//   clk            in   1          single clock; all state is on its rising edge
//   reset          in   1          synchronous, active-high
//   a              in   N_CH       raw asynchronous inputs, one bit per channel
//   mode           in   2*N_CH     per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr            in   N_CH       per-channel clear of event_pending and event_cnt
//   pos_edge       out  N_CH       one-cycle pulse on filtered 0->1
//   neg_edge       out  N_CH       one-cycle pulse on filtered 1->0
//   event_pending  out  N_CH       sticky, set by a mode-qualified edge
//   event_cnt      out  N_CH*CNT_W count of qualified edges; channel i is [i*CNT_W +: CNT_W]
//   any_event      out  1          OR of event_pending (combinational from registers)
// BEHAVIOUR
//   - Reset (clk edge with reset=1) sets every flop to 0:
//     sync chain, filtered level, debounce count, pos/neg_edge, pending, cnt. Hence any_event=0.
//   - Sync: a[i] passes through SYNC_STAGES flops. Call the last stage s[i].
//   - Debounce: filt[i] starts at 0. dcnt[i] increments each cycle s[i]!=filt[i].
//     It returns to 0 on any cycle with s[i]==filt[i].
//     When s[i]!=filt[i] and dcnt==DEBOUNCE-1: filt flips, dcnt<=0, and the edge pulse
//     registers on the same clk edge.
//   - Latency L = SYNC_STAGES+DEBOUNCE edges, counted from the first edge sampling the new
//     a value to the edge where pos/neg_edge rises. Pulses are exactly 1 cycle wide.
//     Edges in back-to-back cycles are impossible when DEBOUNCE>1.
//   - Pulses at s shorter than DEBOUNCE cycles produce no edge.
//   - pos_edge/neg_edge pulse regardless of mode. mode only qualifies pending/cnt.
//   - qualified[i] = (pos & mode[0]) | (neg & mode[1]). It uses mode as sampled on the pulse cycle.
//   - Qualified edge: pending<=1 and cnt<=cnt+1, saturating at 2**CNT_W-1 (no wrap).
//   - clr[i] with no qualified edge: pending<=0, cnt<=0 next edge.
//   - clr[i] with a qualified edge in the same cycle: edge wins, giving pending=1, cnt=1.
//   - a held high through reset: filt=0 after reset, so one pos_edge occurs L edges after
//     reset deasserts. This is intended.
//   - Reset mid-debounce discards the partial count. No pulse from pre-reset activity.
//   - Channels are fully independent. Simultaneous events on several channels are all recorded.
// STRUCTURE
//   - Package edge_det_pkg holds:
//     - typedef enum logic [1:0] {MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH} edge_mode_t
//     - clog2-based helper for the dcnt width
//   - Sub-module edge_detector_chan implements one channel:
//     sync chain, debounce, pulse, pending, cnt.
//   - edge_detector_mc generate-loops N_CH instances and ORs pending into any_event.
// TESTING (defaults: N_CH=4, SYNC_STAGES=2, DEBOUNCE=4, CNT_W=8 -> L=6)
//   1. Reset 3 cycles with a=4'hF -> all outputs 0 during reset.
//      Then pos_edge=4'hF for exactly 1 cycle, 6 edges after release.
//   2. ch0 mode=01, a[0] 0->1 held -> pos_edge[0] 1 cycle after 6 edges, pending[0]=1, cnt0=1.
//      Then a[0] 1->0 -> neg_edge[0] pulses, cnt0 stays 1.
//   3. ch1 mode=11, a[1] high for 3 cycles -> no pulse, cnt1=0.
//      High for 4 cycles -> pos_edge then neg_edge, cnt1=2.
//   4. ch2 mode=11, toggle a[2] every 8 cycles for 300 toggles -> cnt2 stops at 8'hFF.
//      clr[2] -> cnt2=0, pending[2]=0, any_event=0 if others clear.
//   5. ch3 mode=01, clr[3] asserted on the pos_edge[3] cycle -> pending[3]=1, cnt3=1.
//      mode=00 edge -> pulse, cnt unchanged.
//   6. a[0] rises, reset asserted 4 edges later for 1 cycle with a[0] still high
//      -> no pulse before reset, then one pos_edge 6 edges after release.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_det_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_t;

    // Width of a counter that must hold 0..debounce-1; never narrower than one bit.
    function automatic int unsigned dcnt_width(input int unsigned debounce);
        return (debounce > 1) ? int'($clog2(debounce)) : 1;
    endfunction

endpackage

// File: rtl/edge_detector_chan.sv
// One channel: synchroniser, debounce filter, edge pulses, sticky pending flag and event counter.
module edge_detector_chan
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  edge_mode_t       mode,
    input  logic             clr,
    output logic             pos_edge,
    output logic             neg_edge,
    output logic             event_pending,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int unsigned DCNT_W = dcnt_width(DEBOUNCE);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   filt_q;
    logic [DCNT_W-1:0]      dcnt_q;
    logic                   qualified;
    logic [CNT_W-1:0]       cnt_inc;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; bit 0 samples the raw asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a};
        end
    end

    // Debounce: the filtered level flips only after DEBOUNCE consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q   <= 1'b0;
            dcnt_q   <= '0;
            pos_edge <= 1'b0;
            neg_edge <= 1'b0;
        end else if (s != filt_q) begin
            if (dcnt_q == DCNT_LAST) begin
                filt_q   <= s;
                dcnt_q   <= '0;
                pos_edge <= s;
                neg_edge <= ~s;
            end else begin
                dcnt_q   <= dcnt_q + DCNT_W'(1);
                pos_edge <= 1'b0;
                neg_edge <= 1'b0;
            end
        end else begin
            dcnt_q   <= '0;
            pos_edge <= 1'b0;
            neg_edge <= 1'b0;
        end
    end

    assign qualified = (pos_edge & ((mode == MODE_RISE) || (mode == MODE_BOTH)))
                     | (neg_edge & ((mode == MODE_FALL) || (mode == MODE_BOTH)));

    assign cnt_inc = (event_cnt == CNT_MAX) ? CNT_MAX : event_cnt + CNT_ONE;

    // A qualified edge beats a simultaneous clear, restarting the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_pending <= 1'b0;
            event_cnt     <= '0;
        end else if (qualified) begin
            event_pending <= 1'b1;
            event_cnt     <= clr ? CNT_ONE : cnt_inc;
        end else if (clr) begin
            event_pending <= 1'b0;
            event_cnt     <= '0;
        end
    end

endmodule

// File: rtl/edge_detector_mc.sv
// Multi-channel edge detector: N_CH independent channels plus a global event flag.
module edge_detector_mc
    import edge_det_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       a,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH-1:0]       pos_edge,
    output logic [N_CH-1:0]       neg_edge,
    output logic [N_CH-1:0]       event_pending,
    output logic [N_CH*CNT_W-1:0] event_cnt,
    output logic                  any_event
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_detector_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .a             (a[i]),
            .mode          (edge_mode_t'(mode[2*i +: 2])),
            .clr           (clr[i]),
            .pos_edge      (pos_edge[i]),
            .neg_edge      (neg_edge[i]),
            .event_pending (event_pending[i]),
            .event_cnt     (event_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign any_event = |event_pending;

endmodule

// File: tb/tb_edge_detector_mc.sv
// Bench for edge_detector_mc: directed scenarios plus randomized traffic against a window-based model.
module tb_edge_detector_mc;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DEBOUNCE    = 4;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned H           = SYNC_STAGES + DEBOUNCE - 1;
    localparam int          LAT         = SYNC_STAGES + DEBOUNCE;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       a;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       pos_edge;
    logic [N_CH-1:0]       neg_edge;
    logic [N_CH-1:0]       event_pending;
    logic [N_CH*CNT_W-1:0] event_cnt;
    logic                  any_event;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edge_detector_mc #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .a(a), .mode(mode), .clr(clr),
        .pos_edge(pos_edge), .neg_edge(neg_edge), .event_pending(event_pending),
        .event_cnt(event_cnt), .any_event(any_event)
    );

    // Reference: the filtered level flips when the last DEBOUNCE synced samples all differ from it.
    // m_hist bit j holds the raw input sampled j+1 edges ago.
    logic [H-1:0]     m_hist [N_CH];
    logic [N_CH-1:0]  m_filt, m_pos, m_neg, m_pend;
    logic [CNT_W-1:0] m_cnt  [N_CH];

    always @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            automatic logic flip = 1'b1;
            automatic logic qual;
            if (reset) begin
                m_hist[i] <= '0;
                m_filt[i] <= 1'b0;
                m_pos[i]  <= 1'b0;
                m_neg[i]  <= 1'b0;
                m_pend[i] <= 1'b0;
                m_cnt[i]  <= '0;
            end else begin
                for (int j = SYNC_STAGES - 1; j < int'(H); j++)
                    if (m_hist[i][j] == m_filt[i]) flip = 1'b0;
                m_hist[i] <= {m_hist[i][H-2:0], a[i]};
                m_filt[i] <= m_filt[i] ^ flip;
                m_pos[i]  <= flip & ~m_filt[i];
                m_neg[i]  <= flip & m_filt[i];
                qual = (m_pos[i] & mode[2*i]) | (m_neg[i] & mode[2*i+1]);
                if (qual) begin
                    m_pend[i] <= 1'b1;
                    if (clr[i])                  m_cnt[i] <= 1;
                    else if (m_cnt[i] != 8'hFF)  m_cnt[i] <= m_cnt[i] + 1;
                end else if (clr[i]) begin
                    m_pend[i] <= 1'b0;
                    m_cnt[i]  <= '0;
                end
            end
        end
    end

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return event_cnt[ch*CNT_W +: CNT_W];
    endfunction

    task automatic test_reset;
        reset = 1'b1; a = 4'hF; mode = '0; clr = '0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            checks++;
            if ({pos_edge, neg_edge, event_pending, event_cnt, any_event} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: pos=%h neg=%h pend=%h cnt=%h any=%b, required all 0",
                         n, pos_edge, neg_edge, event_pending, event_cnt, any_event);
            end
        end
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (pos_edge !== ((n == LAT) ? 4'hF : 4'h0) || neg_edge !== 4'h0) begin
                errors++;
                $display("FAIL reset_release_pulse edge %0d: pos=%h neg=%h, required pos=%h neg=0",
                         n, pos_edge, neg_edge, (n == LAT) ? 4'hF : 4'h0);
            end
        end
        a = 4'h0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_rise_fall;
        mode = 8'h01;
        a[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (pos_edge[0] !== (n == LAT) || neg_edge[0] !== 1'b0) begin
                errors++;
                $display("FAIL rise_pulse edge %0d: pos0=%b neg0=%b, required pos0=%b neg0=0",
                         n, pos_edge[0], neg_edge[0], n == LAT);
            end
        end
        checks++;
        if (event_pending[0] !== 1'b1 || cnt_of(0) !== 8'd1) begin
            errors++;
            $display("FAIL rise_count: pend0=%b cnt0=%0d, required 1 and 1", event_pending[0], cnt_of(0));
        end
        a[0] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (neg_edge[0] !== (n == LAT) || pos_edge[0] !== 1'b0) begin
                errors++;
                $display("FAIL fall_pulse edge %0d: neg0=%b pos0=%b, required neg0=%b pos0=0",
                         n, neg_edge[0], pos_edge[0], n == LAT);
            end
        end
        checks++;
        if (cnt_of(0) !== 8'd1) begin
            errors++;
            $display("FAIL fall_unqualified: cnt0=%0d, required 1", cnt_of(0));
        end
    endtask

    task automatic test_debounce;
        int npos, nneg;
        mode = 8'h0C;
        a[1] = 1'b1;
        repeat (3) @(negedge clk);
        a[1] = 1'b0;
        npos = 0; nneg = 0;
        repeat (12) begin
            @(negedge clk);
            npos += int'(pos_edge[1]); nneg += int'(neg_edge[1]);
        end
        checks++;
        if (npos != 0 || nneg != 0 || cnt_of(1) !== 8'd0) begin
            errors++;
            $display("FAIL short_glitch: pos=%0d neg=%0d cnt1=%0d, required 0 0 0", npos, nneg, cnt_of(1));
        end
        a[1] = 1'b1;
        repeat (4) @(negedge clk);
        a[1] = 1'b0;
        npos = 0; nneg = 0;
        repeat (16) begin
            @(negedge clk);
            npos += int'(pos_edge[1]); nneg += int'(neg_edge[1]);
        end
        checks++;
        if (npos != 1 || nneg != 1 || cnt_of(1) !== 8'd2) begin
            errors++;
            $display("FAIL min_pulse: pos=%0d neg=%0d cnt1=%0d, required 1 1 2", npos, nneg, cnt_of(1));
        end
    endtask

    task automatic test_saturate;
        mode = 8'h30;
        for (int t = 0; t < 300; t++) begin
            a[2] = ~a[2];
            repeat (8) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (cnt_of(2) !== 8'hFF || event_pending[2] !== 1'b1 || any_event !== 1'b1) begin
            errors++;
            $display("FAIL saturate: cnt2=%h pend2=%b any=%b, required ff 1 1",
                     cnt_of(2), event_pending[2], any_event);
        end
        clr = 4'hF;
        @(negedge clk);
        clr = 4'h0;
        checks++;
        if (cnt_of(2) !== 8'h00 || event_pending !== 4'h0 || any_event !== 1'b0) begin
            errors++;
            $display("FAIL clear_all: cnt2=%h pend=%h any=%b, required 00 0 0",
                     cnt_of(2), event_pending, any_event);
        end
    endtask

    task automatic test_clr_collision;
        bit seen = 0;
        int npos = 0, nneg = 0;
        mode = 8'h40;
        a[3] = 1'b1;
        repeat (10) @(negedge clk);
        a[3] = 1'b0;
        repeat (10) @(negedge clk);
        a[3] = 1'b1;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (pos_edge[3]) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL collision_timeout: pos_edge[3]=0 for 10 cycles, required a pulse");
        end
        clr = 4'h8;
        @(negedge clk);
        clr = 4'h0;
        checks++;
        if (event_pending[3] !== 1'b1 || cnt_of(3) !== 8'd1) begin
            errors++;
            $display("FAIL clr_vs_edge: pend3=%b cnt3=%0d, required 1 1", event_pending[3], cnt_of(3));
        end
        mode = 8'h00;
        a[3] = 1'b0;
        repeat (10) begin @(negedge clk); nneg += int'(neg_edge[3]); end
        a[3] = 1'b1;
        repeat (10) begin @(negedge clk); npos += int'(pos_edge[3]); end
        checks++;
        if (npos != 1 || nneg != 1 || cnt_of(3) !== 8'd1 || event_pending[3] !== 1'b1) begin
            errors++;
            $display("FAIL mode_off: pos=%0d neg=%0d cnt3=%0d pend3=%b, required 1 1 1 1",
                     npos, nneg, cnt_of(3), event_pending[3]);
        end
    endtask

    task automatic test_reset_mid_debounce;
        a = 4'h0; mode = 8'h00;
        repeat (12) @(negedge clk);
        a[0] = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            checks++;
            if (pos_edge !== 4'h0 || neg_edge !== 4'h0) begin
                errors++;
                $display("FAIL pre_reset_pulse edge %0d: pos=%h neg=%h, required 0 0", n, pos_edge, neg_edge);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (pos_edge !== ((n == LAT) ? 4'h1 : 4'h0) || neg_edge !== 4'h0) begin
                errors++;
                $display("FAIL post_reset_pulse edge %0d: pos=%h neg=%h, required pos=%h neg=0",
                         n, pos_edge, neg_edge, (n == LAT) ? 4'h1 : 4'h0);
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (pos_edge !== m_pos || neg_edge !== m_neg || event_pending !== m_pend
                || any_event !== (|m_pend)) begin
                errors++;
                $display("FAIL random_flags cycle %0d: pos=%h neg=%h pend=%h any=%b, required %h %h %h %b",
                         c, pos_edge, neg_edge, event_pending, any_event, m_pos, m_neg, m_pend, |m_pend);
            end
            for (int i = 0; i < N_CH; i++) begin
                checks++;
                if (cnt_of(i) !== m_cnt[i]) begin
                    errors++;
                    $display("FAIL random_cnt cycle %0d ch %0d: cnt=%0d, required %0d", c, i, cnt_of(i), m_cnt[i]);
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(6) == 0) a[i] = ~a[i];
                clr[i] = ($urandom_range(24) == 0);
            end
            if ($urandom_range(60) == 0) mode = 8'($urandom);
            reset = ($urandom_range(400) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rise_fall();
        test_debounce();
        test_saturate();
        test_clr_collision();
        test_reset_mid_debounce();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
